// File: rtl/sensor_conditioner.sv
// Loop-detector front end for traffic_light: per-lane sync, debounce, request
// latch cleared on green service, and sticky stuck-detector fault with recall.
module sensor_conditioner #(
   parameter int DEB_CYCLES   = 4,
   parameter int STUCK_CYCLES = 1000,
   parameter int CNT_W        = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_n,
   input  logic       raw_s,
   input  logic       raw_e,
   input  logic       raw_w,
   input  logic [1:0] n,
   input  logic [1:0] s,
   input  logic [1:0] e,
   input  logic [1:0] w,
   input  logic       fault_clr,
   output logic       nss,
   output logic       sns,
   output logic       ews,
   output logic       wes,
   output logic [3:0] fault
);

   localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_CYCLES);
   localparam logic [1:0]       GREEN     = 2'b10;

   // Lane index: 0 north, 1 south, 2 east, 3 west.
   logic [3:0]       raw;
   logic [3:0]       green;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       deb;
   logic [3:0]       deb_prev;
   logic [3:0]       req;
   logic [3:0]       fault_q;
   logic [CNT_W-1:0] deb_cnt    [4];
   logic [CNT_W-1:0] stuck_cnt  [4];
   logic [CNT_W-1:0] stuck_next [4];

   assign raw   = {raw_w, raw_e, raw_s, raw_n};
   assign green = {w == GREEN, e == GREEN, s == GREEN, n == GREEN};

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         stuck_next[i] = stuck_cnt[i];
         if (!deb[i])
            stuck_next[i] = '0;
         else if (stuck_cnt[i] != STUCK_MAX)
            stuck_next[i] = stuck_cnt[i] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= '0;
         sync2    <= '0;
         deb      <= '0;
         deb_prev <= '0;
         for (int unsigned i = 0; i < 4; i++)
            deb_cnt[i] <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         deb_prev <= deb;
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_MAX) begin
                  deb[i]     <= ~deb[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Green service takes priority over a coincident rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (green[i])
               req[i] <= 1'b0;
            else if (deb[i] && !deb_prev[i])
               req[i] <= 1'b1;
         end
      end
   end

   // Fault is raised on the same edge the counter reaches its limit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fault_q <= '0;
         for (int unsigned i = 0; i < 4; i++)
            stuck_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (fault_clr) begin
               stuck_cnt[i] <= '0;
               fault_q[i]   <= 1'b0;
            end else begin
               stuck_cnt[i] <= stuck_next[i];
               if (stuck_next[i] == STUCK_MAX)
                  fault_q[i] <= 1'b1;
            end
         end
      end
   end

   assign nss   = req[0] | fault_q[0];
   assign sns   = req[1] | fault_q[1];
   assign ews   = req[2] | fault_q[2];
   assign wes   = req[3] | fault_q[3];
   assign fault = fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: expected {fault, wes, ews, sns, nss}
// values are queued per clock edge from hand-derived timing and checked after it.
module tb_sensor_conditioner;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       raw_n = 1'b0, raw_s = 1'b0, raw_e = 1'b0, raw_w = 1'b0;
   logic [1:0] n = 2'b00, s = 2'b00, e = 2'b00, w = 2'b00;
   logic       fault_clr = 1'b0;
   logic       nss, sns, ews, wes;
   logic [3:0] fault;

   int tests_run = 0;
   int fails     = 0;

   typedef struct {
      string      name;
      int         edge_no;
      logic [7:0] val;
   } exp_t;
   exp_t sb[$];

   sensor_conditioner #(
      .DEB_CYCLES  (4),
      .STUCK_CYCLES(20),
      .CNT_W       (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .raw_n    (raw_n),
      .raw_s    (raw_s),
      .raw_e    (raw_e),
      .raw_w    (raw_w),
      .n        (n),
      .s        (s),
      .e        (e),
      .w        (w),
      .fault_clr(fault_clr),
      .nss      (nss),
      .sns      (sns),
      .ews      (ews),
      .wes      (wes),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] observed();
      return {fault, wes, ews, sns, nss};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm, input int k, input logic [7:0] v);
      exp_t x;
      x.name    = nm;
      x.edge_no = k;
      x.val     = v;
      sb.push_back(x);
   endtask

   task automatic idle_inputs();
      raw_n = 1'b0; raw_s = 1'b0; raw_e = 1'b0; raw_w = 1'b0;
      n = 2'b00; s = 2'b00; e = 2'b00; w = 2'b00;
      fault_clr = 1'b0;
   endtask

   // Leaves rst released just after a rising edge; the next edge is edge 1.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      raw_n = 1'b1; raw_s = 1'b1; raw_e = 1'b1; raw_w = 1'b1;
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         exp_t x;
         push("reset_hold", k, 8'h00);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
      raw_s = 1'b0; raw_e = 1'b0; raw_w = 1'b0;
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         exp_t x;
         push("reset_latency", k, (k >= 7) ? 8'h01 : 8'h00);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      raw_e = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         exp_t x;
         if (k == 4) raw_e = 1'b0;
         push("glitch_3cyc", k, 8'h00);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
      do_reset();
      raw_e = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         exp_t x;
         if (k == 5) raw_e = 1'b0;
         push("pulse_4cyc", k, (k >= 7) ? 8'h04 : 8'h00);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
   endtask

   task automatic test_service();
      do_reset();
      raw_w = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         exp_t x;
         if (k == 6)  raw_w = 1'b0;
         if (k == 13) w = 2'b10;
         if (k == 14) w = 2'b00;
         push("service_clear", k, (k >= 7 && k <= 12) ? 8'h08 : 8'h00);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
      do_reset();
      raw_w = 1'b1;
      w = 2'b10;
      for (int k = 1; k <= 16; k++) begin
         exp_t x;
         if (k == 11) begin
            w = 2'b00;
            raw_w = 1'b0;
         end
         push("rise_during_green", k, 8'h00);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
      do_reset();
      raw_w = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         exp_t x;
         if (k == 7) w = 2'b10;
         if (k == 8) w = 2'b00;
         push("set_clear_same_cycle", k, 8'h00);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
   endtask

   task automatic test_multi();
      do_reset();
      raw_n = 1'b1;
      raw_s = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         exp_t x;
         if (k == 8) n = 2'b10;
         if (k == 9) n = 2'b00;
         push("multi_lane", k, (k < 7) ? 8'h00 : (k == 7) ? 8'h03 : 8'h02);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
   endtask

   task automatic test_stuck();
      do_reset();
      raw_s = 1'b1;
      for (int k = 1; k <= 53; k++) begin
         exp_t x;
         logic [7:0] ev;
         if (k == 27) s = 2'b10;
         if (k == 31) fault_clr = 1'b1;
         if (k == 32) fault_clr = 1'b0;
         if (k < 7)        ev = 8'h00;
         else if (k <= 25) ev = 8'h02;
         else if (k <= 30) ev = 8'h22;
         else if (k <= 50) ev = 8'h00;
         else              ev = 8'h22;
         push("stuck_fault", k, ev);
         tick();
         x = sb.pop_front();
         tests_run++;
         if (observed() !== x.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t x;
      do_reset();
      raw_s = 1'b1;
      repeat (26) tick();
      push("async_setup_fault", 26, 8'h22);
      x = sb.pop_front();
      tests_run++;
      if (observed() !== x.val) begin
         fails++;
         $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
      end
      #3;
      rst = 1'b0;
      #1;
      push("async_clear_fault", 0, 8'h00);
      x = sb.pop_front();
      tests_run++;
      if (observed() !== x.val) begin
         fails++;
         $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
      end
      tick();
      idle_inputs();
      rst = 1'b1;
      raw_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         exp_t y;
         if (k == 6) raw_e = 1'b1;
         push("async_pre", k, (k >= 7) ? 8'h01 : 8'h00);
         tick();
         y = sb.pop_front();
         tests_run++;
         if (observed() !== y.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", y.name, y.edge_no, observed(), y.val);
         end
      end
      #3;
      rst = 1'b0;
      #1;
      push("async_mid_debounce", 0, 8'h00);
      x = sb.pop_front();
      tests_run++;
      if (observed() !== x.val) begin
         fails++;
         $display("FAIL %s edge %0d: got %h, expected %h", x.name, x.edge_no, observed(), x.val);
      end
      tick();
      tick();
      rst = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         exp_t y;
         push("async_restart", k, (k == 7) ? 8'h05 : 8'h00);
         tick();
         y = sb.pop_front();
         tests_run++;
         if (observed() !== y.val) begin
            fails++;
            $display("FAIL %s edge %0d: got %h, expected %h", y.name, y.edge_no, observed(), y.val);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_glitch();
      test_service();
      test_multi();
      test_stuck();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
